// File: rtl/dram_access_arbiter.sv
// dram_access_arbiter
// Shares one single-port LUTRAM (synchronous write, asynchronous read) between two
// requesters, A and B. After reset, or on clear_req, every word is swept to INIT_VALUE
// before any request is granted. In RUN, at most one access is granted per cycle, and
// contention between A and B is resolved round-robin.
//
// Handshake: a transfer happens in any cycle where x_valid && x_ready. x_ready is
// combinational from the valids, the FSM state and clear_req. A requester that is not
// granted must hold valid/we/addr/wdata stable until it sees ready. Read data comes
// back as a one-cycle x_rvalid pulse in the cycle after the transfer; there is no
// backpressure on the response. x_rdata holds its value until the next x_rvalid.
module dram_access_arbiter #(
    parameter int                ADDR_W       = 6,
    parameter int                DATA_W       = 8,
    parameter logic [DATA_W-1:0] INIT_VALUE   = '0,
    parameter bit                CLEAR_ON_RST = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear_req,
    output logic              init_done,

    input  logic              a_valid,
    output logic              a_ready,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,

    input  logic              b_valid,
    output logic              b_ready,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,

    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam state_t            RST_STATE = CLEAR_ON_RST ? ST_INIT : ST_RUN;
    localparam logic [ADDR_W-1:0] PTR_LAST  = '1;

    state_t            state_q;
    state_t            state_d;
    logic [ADDR_W-1:0] ptr_q;
    logic [ADDR_W-1:0] ptr_d;
    // Side that wins the next A/B tie: 0 = A, 1 = B.
    logic              prio_q;
    // Last address presented to the RAM, held on idle cycles.
    logic [ADDR_W-1:0] addr_q;
    logic              grant_a;
    logic              grant_b;

    // Next state, grant selection and RAM drive. All combinational outputs are forced
    // low while rst_n is asserted, so nothing reaches the RAM during reset.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        grant_a   = 1'b0;
        grant_b   = 1'b0;
        init_done = 1'b0;
        a_ready   = 1'b0;
        b_ready   = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = addr_q;
        ram_wdata = '0;
        if (rst_n) begin
            case (state_q)
                ST_INIT: begin
                    // Sweep one word per cycle. clear_req has no effect here.
                    ram_we    = 1'b1;
                    ram_addr  = ptr_q;
                    ram_wdata = INIT_VALUE;
                    ptr_d     = ptr_q + 1'b1;
                    if (ptr_q == PTR_LAST) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    init_done = 1'b1;
                    if (clear_req) begin
                        // No grant in the cycle that starts a sweep.
                        state_d = ST_INIT;
                        ptr_d   = '0;
                    end else begin
                        if (a_valid && (!b_valid || !prio_q)) begin
                            grant_a = 1'b1;
                        end else if (b_valid) begin
                            grant_b = 1'b1;
                        end
                        a_ready = grant_a;
                        b_ready = grant_b;
                        if (grant_a) begin
                            ram_addr  = a_addr;
                            ram_we    = a_we;
                            ram_wdata = a_wdata;
                        end else if (grant_b) begin
                            ram_addr  = b_addr;
                            ram_we    = b_we;
                            ram_wdata = b_wdata;
                        end
                    end
                end
                default: begin
                    state_d = RST_STATE;
                    ptr_d   = '0;
                end
            endcase
        end
    end

    // FSM state and sweep pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RST_STATE;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // Round-robin pointer: after a transfer, the other side wins the next tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_q <= 1'b0;
        end else if (grant_a) begin
            prio_q <= 1'b1;
        end else if (grant_b) begin
            prio_q <= 1'b0;
        end
    end

    // Remember the address driven this cycle so that idle cycles keep it on the bus.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= '0;
        end else begin
            addr_q <= ram_addr;
        end
    end

    // Read response for A: capture the async RAM output at the end of the grant cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_rvalid <= 1'b0;
            a_rdata  <= '0;
        end else begin
            a_rvalid <= grant_a & ~a_we;
            if (grant_a && !a_we) begin
                a_rdata <= ram_rdata;
            end
        end
    end

    // Read response for B: same timing as A.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_rvalid <= 1'b0;
            b_rdata  <= '0;
        end else begin
            b_rvalid <= grant_b & ~b_we;
            if (grant_b && !b_we) begin
                b_rdata <= ram_rdata;
            end
        end
    end

endmodule
